// File: rtl/forward_stall_unit.sv
// Forwarding-select and load-use stall control for an ID/EX/MEM/WB pipeline.
// fwd_sel/ex_bubble come straight from stage registers; id_ready is combinational and drops for LOAD_STALL cycles on load-use or while flushing.
module forward_stall_unit #(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*REG_W-1:0] id_rs,
    input  logic [REG_W-1:0]         id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     flush,
    output logic                     id_ready,
    output logic                     ex_bubble,
    output logic [2*NUM_SRC-1:0]     fwd_sel,
    output logic [15:0]              stall_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic [1:0] cnt, cnt_nxt;

    logic                     ex_valid, ex_regwrite, ex_memread;
    logic [REG_W-1:0]         ex_rd;
    logic [NUM_SRC*REG_W-1:0] ex_rs;
    logic                     mem_valid, mem_regwrite;
    logic [REG_W-1:0]         mem_rd;
    logic                     wb_valid, wb_regwrite;
    logic [REG_W-1:0]         wb_rd;

    logic ex_writer, mem_writer, wb_writer;
    logic hazard;
    logic accept;

    assign ex_writer  = ex_valid  && ex_regwrite  && (ex_rd  != '0);
    assign mem_writer = mem_valid && mem_regwrite && (mem_rd != '0);
    assign wb_writer  = wb_valid  && wb_regwrite  && (wb_rd  != '0);

    // Load-use: the load in EX cannot forward its data until it reaches WB.
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_writer && ex_memread) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if ((id_rs[k*REG_W +: REG_W] == ex_rd) && (id_rs[k*REG_W +: REG_W] != '0))
                    hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A single-cycle stall needs no STALL state: the hazard clears once the load leaves EX.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hazard && (LOAD_STALL > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = 2'(LOAD_STALL - 1);
                    end
                end
                STALL: begin
                    if (cnt == 2'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        id_ready = 1'b0;
        if (!flush && (state == IDLE) && !hazard)
            id_ready = 1'b1;
    end

    assign accept = id_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            ex_rs        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
        end else begin
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            if (accept) begin
                ex_valid    <= 1'b1;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_rd       <= id_rd;
                ex_rs       <= id_rs;
            end else begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rd       <= '0;
                ex_rs       <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (id_valid && !id_ready && !flush && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
    end

    // MEM is checked last so the most recent producer wins.
    always_comb begin
        fwd_sel = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ex_valid && (ex_rs[k*REG_W +: REG_W] != '0)) begin
                if (wb_writer && (wb_rd == ex_rs[k*REG_W +: REG_W]))
                    fwd_sel[2*k +: 2] = 2'b10;
                if (mem_writer && (mem_rd == ex_rs[k*REG_W +: REG_W]))
                    fwd_sel[2*k +: 2] = 2'b01;
            end
        end
    end

    assign ex_bubble = !ex_valid;

endmodule

// File: doc/forward_stall_unit.md
FORWARD_STALL_UNIT -- requirements
Module: forward_stall_unit

Interface
REQ-001 The block SHALL use one clock and asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 Parameter REG_W, default 5, SHALL set the register-address width.
REQ-003 Parameter NUM_SRC, default 2, SHALL set the number of source operands per instruction (1..4).
REQ-004 Parameter LOAD_STALL, default 1, SHALL set the stall cycles per load-use hazard (1..3).
REQ-005 Ports SHALL be: id_valid  in  1  ID instruction present; id_rs  in  NUM_SRC*REG_W  source addresses, src k at bits [k*REG_W +: REG_W]; id_rd  in  REG_W  destination; id_regwrite  in  1  writes rd; id_memread  in  1  is a load; flush  in  1  kill ID and EX contents.
REQ-006 Outputs SHALL be: id_ready  out  1  ID instruction accepted this cycle; ex_bubble  out  1  EX stage holds no valid instruction; fwd_sel  out  2*NUM_SRC  per-source EX forward select, src k at [2k +: 2]; stall_count  out  16  saturating stall-cycle counter.

Function
REQ-007 The block SHALL hold internal stage registers EX, MEM, WB, each {valid, rd, regwrite, memread, rs[NUM_SRC]} (rs in EX only).
REQ-008 Each cycle MEM SHALL load EX and WB SHALL load MEM unconditionally.
REQ-009 EX SHALL load the ID fields with valid=1 when id_valid && id_ready, otherwise a bubble (valid=0, regwrite=0, memread=0).
REQ-010 A stage SHALL count as writer only when valid && regwrite && rd != 0.
REQ-011 Load-use hazard SHALL be: id_valid && EX writer && EX.memread && some id_rs[k] == EX.rd with id_rs[k] != 0.
REQ-012 FSM states SHALL be IDLE and STALL, with a stall counter of 2 bits.
REQ-013 IDLE: hazard -> id_ready=0, go STALL with counter=LOAD_STALL-1 if LOAD_STALL>1, else stay IDLE (single-cycle stall re-evaluated next cycle, no longer matches since load moved to MEM).
REQ-014 STALL: id_ready=0; counter decrements each cycle; at counter==1 -> IDLE; hazard detection SHALL be ignored while in STALL.
REQ-015 id_ready SHALL be 1 in IDLE with no hazard, regardless of id_valid.
REQ-016 fwd_sel[k] SHALL be 2'b01 if MEM writer and MEM.rd == EX.rs[k]; else 2'b10 if WB writer and WB.rd == EX.rs[k]; else 2'b00; forced 2'b00 when EX.valid=0 or EX.rs[k]==0.
REQ-017 MEM match SHALL take priority over WB match (most recent value).
REQ-018 fwd_sel and ex_bubble SHALL depend only on stage registers (no combinational path from inputs); id_ready MAY depend combinationally on inputs.
REQ-019 ex_bubble SHALL equal !EX.valid.
REQ-020 stall_count SHALL increment by 1 on each cycle with id_valid && !id_ready, saturating at 16'hFFFF.
REQ-021 flush SHALL, at the next edge, load EX with a bubble, return FSM to IDLE and clear the counter; MEM and WB SHALL still advance normally; flush has priority over any stall.
REQ-022 During flush cycle id_ready SHALL be 0 (ID instruction discarded) and stall_count SHALL not increment.

Reset
REQ-023 rst SHALL asynchronously clear all stage valid/regwrite/memread bits, rd/rs to 0, FSM to IDLE, stall counter to 0, stall_count to 0.
REQ-024 During and after reset, outputs SHALL read id_ready=1, ex_bubble=1, fwd_sel=0, stall_count=0; reset mid-STALL SHALL abort the stall.

Verification
REQ-025 ALU chain: issue add x3 (rd=3,regwrite), next cycle issue rs0=3, rs1=4 -> when consumer in EX, fwd_sel=4'b0001; no stall.
REQ-026 Distance-2: rd=3 writer, one unrelated instr, then rs1=3 -> fwd_sel[3:2]=2'b10 in consumer's EX cycle.
REQ-027 Priority: two back-to-back writers of x5, then rs0=5 -> fwd_sel[1:0]=2'b01.
REQ-028 Load-use, LOAD_STALL=1: load rd=7, next rs0=7 -> id_ready=0 for 1 cycle, ex_bubble=1 one cycle, consumer reaches EX with fwd_sel[1:0]=2'b10, stall_count=1; repeat with LOAD_STALL=3 -> 3 stall cycles, stall_count=3.
REQ-029 x0: writer with rd=0, consumer rs0=0 and load rd=0 with rs0=0 -> fwd_sel=0, no stall.
REQ-030 Flush/reset mid-stall: LOAD_STALL=3, assert flush (then separately rst) in second stall cycle -> id_ready=1 next cycle, ex_bubble=1, stall_count unchanged (flush) / 0 (rst).
